pipe_seq_ctrl: RTL and testbench
================================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: the MEM_WAIT cycle at which the wait counter reaches this value moves the FSM to ERR.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 ex_rd  input  5  destination register number of the instruction in EX.
REQ-007 ex_memread  input  1  instruction in EX is a load.
REQ-008 branch_taken  input  1  EX resolved a taken branch or jump.
REQ-009 dmem_req  input  1  MEM stage is accessing data memory this cycle.
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  load enables for the PC and the pipeline registers.
REQ-012 if_id_flush, id_ex_flush  output  1 each  clear the named register to a NOP on the next edge.
REQ-013 mem_wb_bubble  output  1  forces RegWrite=0 and MemToReg=0 into MEM_WB.
REQ-014 err  output  1  sticky memory-timeout error flag.
REQ-015 stall_cnt  output  CNT_W  count of cycles with pc_en=0.
REQ-016 state  output  2  current FSM state encoding.

Function
REQ-017 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, ERR=2; encoding 3 is illegal and SHALL go to ERR.
REQ-018 memstall = dmem_req && !dmem_ready.
REQ-019 loaduse = ex_memread && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt).
REQ-020 Control outputs are combinational from state and current inputs; state, the wait counter, err and stall_cnt are registered.
REQ-021 In RUN with memstall: pc/if_id/id_ex/ex_mem enables 0, mem_wb_en=1, mem_wb_bubble=1, no flushes; next state MEM_WAIT.
REQ-022 In RUN without memstall, with branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-023 In RUN without memstall or branch_taken, with loaduse: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1 (one-cycle bubble).
REQ-024 Priority: memstall > branch_taken > loaduse. Branch SHALL suppress loaduse in the same cycle.
REQ-025 In RUN with none of the three conditions: all enables 1, all flushes and mem_wb_bubble 0.
REQ-026 In MEM_WAIT with dmem_ready=0: same outputs as REQ-021, and the wait counter increments.
REQ-027 In MEM_WAIT with dmem_ready=1: outputs are evaluated per REQ-022..REQ-025 (release in that same cycle), next state RUN, wait counter cleared.
REQ-028 In MEM_WAIT with dmem_ready=0, the cycle the wait counter increments to MAX_WAIT SHALL set next state ERR.
REQ-029 The wait counter SHALL be clog2(MAX_WAIT+1) bits and clear on every entry to MEM_WAIT.
REQ-030 ERR: all enables 0, mem_wb_bubble=1, err=1; the FSM leaves ERR only on reset.
REQ-031 stall_cnt SHALL increment on every cycle with pc_en=0, outside reset, saturating at 2^CNT_W-1.
REQ-032 A branch_taken held during MEM_WAIT SHALL take effect only in the release cycle, exactly once.

Reset
REQ-033 While reset is high: state=RUN, wait counter=0, err=0, stall_cnt=0, all enables 0, flushes 0, mem_wb_bubble 0.
REQ-034 Reset asserted mid-MEM_WAIT or in ERR SHALL return to RUN immediately (asynchronously), without waiting for a clock edge.
REQ-035 The first cycle after reset deassertion SHALL evaluate as RUN.

Structure
REQ-036 Package pipe_ctrl_pkg SHALL hold the state enum, the register-number width (5) and the state encodings.
REQ-037 Load-use comparison SHALL be one combinational sub-module, load_use_detect; the FSM and counters stay in pipe_seq_ctrl.

Verification
REQ-038 ex_memread=1, ex_rd=8, id_rs=8 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1 afterwards.
REQ-039 ex_memread=1, ex_rd=0, id_rs=0 -> no stall; all enables 1.
REQ-040 branch_taken=1 together with a load-use hit -> if_id_flush=1, id_ex_flush=1, pc_en=1.
REQ-041 dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles with mem_wb_bubble=1, release on the 4th cycle, state back to RUN, stall_cnt=3.
REQ-042 dmem_ready held low, MAX_WAIT=15 -> state=ERR and err=1 after the wait counter reaches 15; assert reset mid-ERR -> state=0, err=0 with no clock edge.
REQ-043 CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types and constants for the pipeline ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_seq_ctrl_if : hazard inputs and stage-control outputs         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pipe_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport slave (
    input  id_rs, id_rt, ex_rd, ex_memread, branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, err, stall_cnt, state
  );

  modport master (
    output id_rs, id_rt, ex_rd, ex_memread, branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, err, stall_cnt, state
  );

endinterface
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_use_detect : flags an ID source that depends on a load in EX  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  wire logic             ex_memread,
  input  wire logic [REG_W-1:0] ex_rd,
  input  wire logic [REG_W-1:0] id_rs,
  input  wire logic [REG_W-1:0] id_rt,
  output logic                  hit
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hit = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule
`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_seq_ctrl : stall/flush sequencer with memory-wait timeout     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pipe_seq_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic memstall, loaduse, freeze, release_run;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  load_use_detect u_load_use_detect (
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .hit        (loaduse)
  );

  assign memstall = bus.dmem_req && !bus.dmem_ready;
  assign wait_inc = wait_q + WAIT_W'(1);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    freeze        = 1'b0;
    release_run   = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end else begin
          release_run = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          freeze = 1'b1;
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(MAX_WAIT)) state_d = ST_ERR;
        end else begin
          release_run = 1'b1;
          state_d     = ST_RUN;
          wait_d      = '0;
        end
      end
      default: state_d = ST_ERR;  // ERR and the unused encoding both lock up here
    endcase

    if (freeze) begin
      mem_wb_en     = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (release_run) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      if (bus.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (loaduse) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end else begin
      mem_wb_bubble = 1'b1;
    end

    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  assign err_d       = err_q || (state_d == ST_ERR);
  assign stall_cnt_d = (!pc_en && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_en     = mem_wb_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.err           = err_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_seq_ctrl : directed checks of the pipeline sequencer       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_seq_ctrl;

  logic clk;
  logic reset;

  pipe_seq_ctrl_if #(.CNT_W(16)) bus  ();
  pipe_seq_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_seq_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  pipe_seq_ctrl #(.MAX_WAIT(15), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Narrow-counter instance mirrors the main stimulus
  assign bus4.id_rs        = bus.id_rs;
  assign bus4.id_rt        = bus.id_rt;
  assign bus4.ex_rd        = bus.ex_rd;
  assign bus4.ex_memread   = bus.ex_memread;
  assign bus4.branch_taken = bus.branch_taken;
  assign bus4.dmem_req     = bus.dmem_req;
  assign bus4.dmem_ready   = bus.dmem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble}
  localparam logic [7:0] C_NORMAL  = 8'b11111_000;
  localparam logic [7:0] C_LOADUSE = 8'b00111_010;
  localparam logic [7:0] C_BRANCH  = 8'b11111_110;
  localparam logic [7:0] C_FREEZE  = 8'b00001_001;
  localparam logic [7:0] C_ERR     = 8'b00000_001;
  localparam logic [7:0] C_RESET   = 8'b00000_000;

  logic [7:0] ctl;
  assign ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic mr, input logic br, input logic rq, input logic rdy);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.ex_rd        = rd;
    bus.ex_memread   = mr;
    bus.branch_taken = br;
    bus.dmem_req     = rq;
    bus.dmem_ready   = rdy;
  endtask

  initial begin
    reset = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #3;
    check_eq("reset_ctl",   32'(ctl), 32'(C_RESET));
    check_eq("reset_state", 32'(bus.state), 32'd0);
    check_eq("reset_err",   32'(bus.err), 32'd0);
    check_eq("reset_stall", 32'(bus.stall_cnt), 32'd0);
    tick();
    reset = 1'b0;

    // Idle pipeline
    #4;
    check_eq("idle_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();

    // Load-use on rs
    set_in(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("lu_rs_ctl", 32'(ctl), 32'(C_LOADUSE));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rs_stall", 32'(bus.stall_cnt), 32'd1);

    // Load-use on rt
    set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("lu_rt_ctl", 32'(ctl), 32'(C_LOADUSE));
    tick();

    // Load to r0 is not a hazard
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("lu_r0_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();

    // Matching register but not a load
    set_in(5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("noload_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();

    // Branch overrides load-use
    set_in(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    #4;
    check_eq("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
    tick();
    check_eq("br_lu_stall", 32'(bus.stall_cnt), 32'd2);

    // Memory stall of 3 cycles with a branch held throughout
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check_eq($sformatf("mw_freeze%0d_ctl", i), 32'(ctl), 32'(C_FREEZE));
      check_eq($sformatf("mw_freeze%0d_state", i), 32'(bus.state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #4;
    check_eq("mw_release_ctl", 32'(ctl), 32'(C_BRANCH));
    tick();
    check_eq("mw_release_state", 32'(bus.state), 32'd0);
    check_eq("mw_stall", 32'(bus.stall_cnt), 32'd5);
    check_eq("mw_stall4", 32'(bus4.stall_cnt), 32'd5);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("post_release_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();

    // Memory never ready: one RUN cycle plus 15 wait cycles, then ERR
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      #4;
      if (i == 15) begin
        check_eq("to_last_wait_state", 32'(bus.state), 32'd1);
        check_eq("to_last_wait_err",   32'(bus.err), 32'd0);
      end
      tick();
    end
    check_eq("to_err_state", 32'(bus.state), 32'd2);
    check_eq("to_err_flag",  32'(bus.err), 32'd1);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #4;
    check_eq("err_ctl", 32'(ctl), 32'(C_ERR));
    tick();
    tick();
    check_eq("err_sticky_state", 32'(bus.state), 32'd2);
    check_eq("err_stall",  32'(bus.stall_cnt), 32'd23);
    check_eq("sat_stall4", 32'(bus4.stall_cnt), 32'd15);

    // Asynchronous reset from ERR
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_state", 32'(bus.state), 32'd0);
    check_eq("async_rst_err",   32'(bus.err), 32'd0);
    check_eq("async_rst_stall", 32'(bus.stall_cnt), 32'd0);
    check_eq("async_rst_ctl",   32'(ctl), 32'(C_RESET));
    tick();
    reset = 1'b0;

    // First cycle after reset behaves as RUN
    set_in(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    #4;
    check_eq("post_rst_ctl", 32'(ctl), 32'(C_LOADUSE));
    tick();
    check_eq("post_rst_stall", 32'(bus.stall_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
